// File: rtl/top_sync_m_pkg.sv
// rtl/top_sync_m_pkg.sv - shared constants and helpers for the top-level token synchronizer
// Purpose: default channel depths, error-vector bit positions and a width helper.
// Ports: none (package).
package top_sync_m_pkg;

  localparam int AMSyncDepth = 2;
  localparam int MVSyncDepth = 2;

  // Bit positions inside the 2-bit errOvf/errUdf vectors.
  typedef enum int {
    ChAm = 0,
    ChMv = 1
  } syncChan_e;

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/top_sync_m_if.sv
// rtl/top_sync_m_if.sv - TopSync2MCtrl link between MCtrl and the top-level synchronizer
// Purpose: carries the am read pulse, mv write pulse and amEmpty between MCtrl and TopSync.
// Modports: MCtrlSide (master), TopSyncSide (slave), LoaderSide (observes amFull).
// Signals: amRSync, mvWSync (MCtrl -> TopSync), amEmpty (TopSync -> MCtrl), amFull (loader stall).
interface TopSync2MCtrl;
  logic amRSync;
  logic mvWSync;
  logic amEmpty;
  logic amFull;

  modport MCtrlSide (
    output amRSync,
    output mvWSync,
    input  amEmpty,
    input  amFull
  );

  modport TopSyncSide (
    input  amRSync,
    input  mvWSync,
    output amEmpty
  );

  modport LoaderSide (
    input amFull
  );
endinterface

// File: rtl/top_sync_m_sync_token_ctr.sv
// rtl/top_sync_m_sync_token_ctr.sv - saturating up/down token counter with sticky error flags
// Purpose: counts outstanding tokens 0..Depth; illegal pulses are dropped and flagged.
// Ports: clk, rst (sync, active-high), wSync/rSync (token in/out pulses), clrErr,
//        cnt (count), empty/full (decoded from cnt), ovf/udf (sticky errors).
module sync_token_ctr #(
  parameter int Depth = 2,
  parameter int CntW  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wSync,
  input  logic            rSync,
  input  logic            clrErr,
  output logic [CntW-1:0] cnt,
  output logic            empty,
  output logic            full,
  output logic            ovf,
  output logic            udf
);

  localparam logic [CntW-1:0] DepthC = CntW'(Depth);

  logic [CntW-1:0] cntNext;
  logic            ovfSet;
  logic            udfSet;

  assign empty = (cnt == '0);
  assign full  = (cnt == DepthC);

  always_comb begin
    cntNext = cnt;
    ovfSet  = 1'b0;
    udfSet  = 1'b0;
    case ({wSync, rSync})
      2'b10: begin
        if (full) ovfSet = 1'b1;
        else      cntNext = cnt + CntW'(1);
      end
      2'b01: begin
        if (empty) udfSet = 1'b1;
        else       cntNext = cnt - CntW'(1);
      end
      2'b11: begin
        // At zero the read has nothing to take, but the write still lands.
        // When full, the read frees the slot the write fills, so no overflow.
        if (empty) begin
          udfSet  = 1'b1;
          cntNext = CntW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      cnt <= cntNext;
      // A new error in the same cycle as clrErr leaves the flag set.
      ovf <= ovfSet | (ovf & ~clrErr);
      udf <= udfSet | (udf & ~clrErr);
    end
  end

endmodule

// File: rtl/top_sync_m.sv
// rtl/top_sync_m.sv - top-level synchronizer, TopSyncSide responder of TopSync2MCtrl
// Purpose: am (loader -> MCtrl) and mv (MCtrl -> vector stage) token channels.
// Ports: clk, rst, syncIf (amRSync, mvWSync in; amEmpty out), amWSync, amFull,
//        mvRSync, mvEmpty, mvFull, amCnt, mvCnt, errOvf/errUdf ([0]=am, [1]=mv), clrErr.
module top_sync_m
  import top_sync_m_pkg::*;
#(
  parameter int AMDepth = AMSyncDepth,
  parameter int MVDepth = MVSyncDepth,
  parameter int CntW    = $clog2(maxInt(AMDepth, MVDepth) + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  TopSync2MCtrl.TopSyncSide       syncIf,
  input  logic                    amWSync,
  output logic                    amFull,
  input  logic                    mvRSync,
  output logic                    mvEmpty,
  output logic                    mvFull,
  output logic [CntW-1:0]         amCnt,
  output logic [CntW-1:0]         mvCnt,
  output logic [1:0]              errOvf,
  output logic [1:0]              errUdf,
  input  logic                    clrErr
);

  logic amEmptyInt;

  assign syncIf.amEmpty = amEmptyInt;

  sync_token_ctr #(
    .Depth (AMDepth),
    .CntW  (CntW)
  ) amCtr (
    .clk    (clk),
    .rst    (rst),
    .wSync  (amWSync),
    .rSync  (syncIf.amRSync),
    .clrErr (clrErr),
    .cnt    (amCnt),
    .empty  (amEmptyInt),
    .full   (amFull),
    .ovf    (errOvf[ChAm]),
    .udf    (errUdf[ChAm])
  );

  sync_token_ctr #(
    .Depth (MVDepth),
    .CntW  (CntW)
  ) mvCtr (
    .clk    (clk),
    .rst    (rst),
    .wSync  (syncIf.mvWSync),
    .rSync  (mvRSync),
    .clrErr (clrErr),
    .cnt    (mvCnt),
    .empty  (mvEmpty),
    .full   (mvFull),
    .ovf    (errOvf[ChMv]),
    .udf    (errUdf[ChMv])
  );

endmodule

// File: tb/tb_top_sync_m.sv
// tb/tb_top_sync_m.sv - directed table-driven bench for top_sync_m
module tb_top_sync_m;

  logic       clk = 1'b0;
  logic       rst;
  logic       amWSync;
  logic       amFull;
  logic       mvRSync;
  logic       mvEmpty;
  logic       mvFull;
  logic [1:0] amCnt;
  logic [1:0] mvCnt;
  logic [1:0] errOvf;
  logic [1:0] errUdf;
  logic       clrErr;

  int nChecks = 0;
  int nPass   = 0;

  TopSync2MCtrl syncIf ();
  assign syncIf.amFull = amFull;

  top_sync_m dut (
    .clk     (clk),
    .rst     (rst),
    .syncIf  (syncIf),
    .amWSync (amWSync),
    .amFull  (amFull),
    .mvRSync (mvRSync),
    .mvEmpty (mvEmpty),
    .mvFull  (mvFull),
    .amCnt   (amCnt),
    .mvCnt   (mvCnt),
    .errOvf  (errOvf),
    .errUdf  (errUdf),
    .clrErr  (clrErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, amW, amR, mvW, mvR, clr;
    logic [1:0] eAmCnt, eMvCnt;
    logic       eAmE, eAmF, eMvE, eMvF;
    logic [1:0] eOvf, eUdf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, aw, ar, mw, mr, c,
                              input logic [1:0] ac, mc,
                              input logic ae, af, me, mf,
                              input logic [1:0] ov, ud);
    vec_t v;
    v.rst = r; v.amW = aw; v.amR = ar; v.mvW = mw; v.mvR = mr; v.clr = c;
    v.eAmCnt = ac; v.eMvCnt = mc;
    v.eAmE = ae; v.eAmF = af; v.eMvE = me; v.eMvF = mf;
    v.eOvf = ov; v.eUdf = ud;
    return v;
  endfunction

  task automatic check(input string name, input int step, input int act, input int exp);
    nChecks++;
    if (act == exp) nPass++;
    else $display("FAIL %s step %0d: got %0d, want %0d", name, step, act, exp);
  endtask

  task automatic drive(input vec_t v);
    rst            = v.rst;
    amWSync        = v.amW;
    syncIf.amRSync = v.amR;
    syncIf.mvWSync = v.mvW;
    mvRSync        = v.mvR;
    clrErr         = v.clr;
  endtask

  task automatic checkAll(input int step, input vec_t v);
    check("amCnt",   step, int'(amCnt),          int'(v.eAmCnt));
    check("mvCnt",   step, int'(mvCnt),          int'(v.eMvCnt));
    check("amEmpty", step, int'(syncIf.amEmpty), int'(v.eAmE));
    check("amFull",  step, int'(amFull),         int'(v.eAmF));
    check("mvEmpty", step, int'(mvEmpty),        int'(v.eMvE));
    check("mvFull",  step, int'(mvFull),         int'(v.eMvF));
    check("errOvf",  step, int'(errOvf),         int'(v.eOvf));
    check("errUdf",  step, int'(errUdf),         int'(v.eUdf));
  endtask

  task automatic step(input int idx, input vec_t v);
    drive(v);
    @(posedge clk);
    #1;
    checkAll(idx, v);
    @(negedge clk);
  endtask

  initial begin
    vec_t idle, rstV;
    //          rst aw ar mw mr clr  amC    mvC   aE aF mE mF  ovf    udf
    // am fill to full, third write overflows
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 2'd1, 2'd0, 0, 0, 1, 0, 2'b00, 2'b00));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 2'd2, 2'd0, 0, 1, 1, 0, 2'b00, 2'b00));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 2'd2, 2'd0, 0, 1, 1, 0, 2'b01, 2'b00));
    // simultaneous R/W while full: no change, no new error
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0, 1, 1, 0, 0, 0, 2'd2, 2'd0, 0, 1, 1, 0, 2'b01, 2'b00));
    // drain am to zero
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 2'd1, 2'd0, 0, 0, 1, 0, 2'b01, 2'b00));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 2'd0, 2'd0, 1, 0, 1, 0, 2'b01, 2'b00));
    // simultaneous R/W at zero: write lands, read underflows
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 2'd1, 2'd0, 0, 0, 1, 0, 2'b01, 2'b01));
    // mv latency and underflow
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 2'd1, 2'd1, 0, 0, 0, 0, 2'b01, 2'b01));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 2'd1, 2'd0, 0, 0, 1, 0, 2'b01, 2'b01));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 2'd1, 2'd0, 0, 0, 1, 0, 2'b01, 2'b11));
    // clrErr alone clears flags, count untouched
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 2'd1, 2'd0, 0, 0, 1, 0, 2'b00, 2'b00));
    // clrErr coinciding with am overflow: set wins
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 2'd2, 2'd0, 0, 1, 1, 0, 2'b00, 2'b00));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 2'd2, 2'd0, 0, 1, 1, 0, 2'b01, 2'b00));
    // mv fill, full R/W, overflow, then one read back to 1
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 2'd2, 2'd1, 0, 1, 0, 0, 2'b01, 2'b00));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 2'd2, 2'd2, 0, 1, 0, 1, 2'b01, 2'b00));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 2'd2, 2'd2, 0, 1, 0, 1, 2'b01, 2'b00));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 2'd2, 2'd2, 0, 1, 0, 1, 2'b11, 2'b00));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 2'd2, 2'd1, 0, 1, 0, 0, 2'b11, 2'b00));

    idle = mk(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 0, 1, 0, 2'b00, 2'b00);
    // reset with every Sync input high: inputs must be ignored
    rstV = mk(1, 1, 1, 1, 1, 1, 2'd0, 2'd0, 1, 0, 1, 0, 2'b00, 2'b00);

    drive(idle);
    @(negedge clk);
    step(0, rstV);
    for (int i = 0; i < 5; i++) step(1 + i, idle);

    for (int i = 0; i < vecs.size(); i++) step(10 + i, vecs[i]);

    // mid-stream reset at counts 2/1 with errors set, then stay idle
    step(100, rstV);
    step(101, idle);
    step(102, idle);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/top_sync_m.md
# top_sync_m

Top-level synchronizer, TopSyncSide responder of the TopSync2MCtrl link. It tracks two token channels with saturating credit counters. The am channel carries tiles that the loader has written into the A/W/Scale buffers and that MCtrl consumes. The mv channel carries output tiles that MCtrl/MArray finished into OBuffer and that the vector stage consumes. It drives `amEmpty` to MCtrl, plus full/empty and status toward the loader and the vector stage.

## Interface
- `AMDepth`, default `2`: max outstanding am tokens (A/W buffer slots, double-buffered).
- `MVDepth`, default `2`: max outstanding mv tokens (OBuffer slots).
- `CntW`, default `$clog2(max(AMDepth,MVDepth)+1)`: width of the count outputs.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `amWSync` in 1: loader pulse; one tile has landed in the buffers.
- `amRSync` in 1: MCtrl pulse; one tile consumed (TopSync2MCtrl).
- `amEmpty` out 1: no am token available (TopSync2MCtrl).
- `amFull` out 1: am count equals `AMDepth`; the loader must stall.
- `mvWSync` in 1: MCtrl pulse; one output tile committed (TopSync2MCtrl).
- `mvRSync` in 1: vector-stage pulse; one output tile consumed.
- `mvEmpty` out 1: no mv token available.
- `mvFull` out 1: mv count equals `MVDepth`.
- `amCnt` out `CntW`: current am token count.
- `mvCnt` out `CntW`: current mv token count.
- `errOvf` out 2: sticky overflow flags, [0]=am, [1]=mv.
- `errUdf` out 2: sticky underflow flags, [0]=am, [1]=mv.
- `clrErr` in 1: clears `errOvf` and `errUdf`.

## Operation
- Every Sync input is a level sampled each cycle. Each cycle it is high means exactly one event. Back-to-back pulses are legal.
- Each channel is an independent up/down counter `cnt` in the range 0..Depth.
- Per channel, per cycle, with W = write pulse and R = read pulse:
  - W only, cnt<Depth: cnt+1.
  - W only, cnt==Depth: ignored; set errOvf.
  - R only, cnt>0: cnt−1.
  - R only, cnt==0: ignored; set errUdf.
  - W and R, 0<cnt: cnt unchanged. This includes cnt==Depth, because the read frees the slot in the same cycle, so no overflow.
  - W and R, cnt==0: the read is an underflow and is ignored, setting errUdf. The write applies, so cnt becomes 1.
- Derived outputs: `Empty = (cnt==0)`, `Full = (cnt==Depth)`. Both are decoded from the count register only; they do not depend combinationally on the inputs.
- Error flags:
  - Sticky until `clrErr` or `rst`.
  - If `clrErr` coincides with a new error, the flag ends set (set wins).
  - Counters are never modified by `clrErr`.
- The two channels share no state. Activity on am never affects mv.

## Timing
- On reset, all counts are 0. After reset: `amEmpty=1`, `mvEmpty=1`, `amFull=0`, `mvFull=0`, `errOvf=0`, `errUdf=0`.
- Sync inputs are ignored during the `rst` cycle. Reset mid-operation discards all tokens.
- Latency: a pulse in cycle N is reflected in `cnt`, `Empty` and `Full` at cycle N+1.
  - Example: `amWSync` at N with cnt=0 gives `amEmpty=0` at N+1. MCtrl may issue `amRSync` at N+1 at the earliest.
- Handshake rule: the producer must not pulse while `Full` is high and the consumer must not pulse while `Empty` is high. The simultaneous-R/W full case above is the only exception. Violations are recorded, never corrupt the count, and the count never wraps.
- Error flags update at N+1 relative to the offending pulse.

## Structure
- Add to Common:
  - `AMSyncDepth = 2`, `MVSyncDepth = 2`, which are the parameter defaults.
  - Modport additions to TopSync2MCtrl for `amFull` and the loader side, kept in the interface file.
- Sub-module `sync_token_ctr`:
  - Parameters: `Depth`, `CntW`.
  - Ports: `clk`, `rst`, `wSync`, `rSync`, `clrErr`, `cnt`, `empty`, `full`, `ovf`, `udf`.
  - Instantiated twice, once for am and once for mv.
- The top binds `TopSync2MCtrl.TopSyncSide` to the am read, mv write and `amEmpty` signals. The remaining ports are plain.

## Test plan
1. Reset, then idle 5 cycles: `amCnt=mvCnt=0`, `amEmpty=mvEmpty=1`, `amFull=mvFull=0`, `errOvf=errUdf=0`.
2. `amWSync` ×3 on consecutive cycles with AMDepth=2:
   - `amCnt` reads 1, then 2, then stays 2.
   - `amFull=1` from cycle 2.
   - `errOvf[0]=1` after the third pulse.
   - mv channel unchanged.
3. With amCnt=2, `amWSync` and `amRSync` together for 4 cycles: `amCnt` stays 2, `amFull` stays 1, no new errOvf.
4. With amCnt=0, `amWSync` and `amRSync` together: `amCnt=1`, `errUdf[0]=1`, `amEmpty=0` next cycle.
5. mv channel:
   - `mvWSync` at N gives `mvEmpty=0` at N+1.
   - `mvRSync` at N+1 gives `mvEmpty=1` at N+2.
   - `mvRSync` again at N+2 gives `errUdf[1]=1` and `mvCnt` stays 0.
6. Errors set and `amCnt=1`:
   - `clrErr` alone clears both flag vectors; `amCnt` stays 1.
   - `clrErr` with an am overflow leaves `errOvf[0]=1`.
   - `rst` mid-stream, with counts 2/1, gives all zero and both Empty=1 next cycle.
